// File: rtl/spi_frame_if.sv
// SPI pin bundle plus the decoded frame outputs of spi_frame_receiver.
interface spi_frame_if;
  logic       sck;
  logic       sdi;
  logic       cs_n;
  logic [7:0] command;
  logic [7:0] databyte1;
  logic [7:0] databyte2;
  logic       spi_done;
  logic       frame_error;
  logic       busy;

  modport master (
    output sck, sdi, cs_n,
    input  command, databyte1, databyte2, spi_done, frame_error, busy
  );
  modport slave (
    input  sck, sdi, cs_n,
    output command, databyte1, databyte2, spi_done, frame_error, busy
  );
endinterface

// File: rtl/spi_frame_receiver.sv
// SPI mode-0 slave: synchronises sck/sdi/cs_n into clk and deserialises each
// cs_n-framed transaction into command/databyte1/databyte2; bad frames are dropped.
module spi_frame_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 24
) (
  input  logic         clk,
  input  logic         reset,
  spi_frame_if.slave   bus
);
  localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_SAT  = 5'(FRAME_BITS + 1);

  typedef enum logic {IDLE, RECV} state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, sdi_sync_q, cs_sync_q;
  logic [SYNC_STAGES-1:0] sck_sync_d, sdi_sync_d, cs_sync_d;
  logic                   sck_prev_q, cs_prev_q;
  logic                   sck_s, sdi_s, cs_s;
  logic                   sck_rise, cs_rise, cs_fall;

  state_e                 state_q, state_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [4:0]             cnt_q, cnt_d;
  logic                   eval_q, eval_d;
  logic [7:0]             command_q, command_d;
  logic [7:0]             databyte1_q, databyte1_d;
  logic [7:0]             databyte2_q, databyte2_d;
  logic                   spi_done_q, spi_done_d;
  logic                   frame_error_q, frame_error_d;
  logic                   busy_q, busy_d;

  assign sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
  assign sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], bus.sdi};
  assign cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0],  bus.cs_n};

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    eval_d        = 1'b0;
    command_d     = command_q;
    databyte1_d   = databyte1_q;
    databyte2_d   = databyte2_q;
    spi_done_d    = 1'b0;
    frame_error_d = 1'b0;

    // Frame verdict lands one cycle after the cs_n rise took us back to IDLE.
    if (eval_q) begin
      if (cnt_q == CNT_FULL) begin
        command_d   = shift_q[23:16];
        databyte1_d = shift_q[15:8];
        databyte2_d = shift_q[7:0];
        spi_done_d  = 1'b1;
      end else begin
        frame_error_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          shift_d = '0;
          cnt_d   = '0;
          state_d = RECV;
        end
      end
      RECV: begin
        if (cs_rise) begin
          state_d = IDLE;
          eval_d  = 1'b1;
        end else if (cs_fall) begin
          shift_d = '0;
          cnt_d   = '0;
        end else if (sck_rise && !cs_s) begin
          shift_d = {shift_q[FRAME_BITS-2:0], sdi_s};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RECV);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync_q    <= '0;
      sdi_sync_q    <= '0;
      cs_sync_q     <= '1;
      sck_prev_q    <= 1'b0;
      cs_prev_q     <= 1'b1;
      state_q       <= IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      eval_q        <= 1'b0;
      command_q     <= '0;
      databyte1_q   <= '0;
      databyte2_q   <= '0;
      spi_done_q    <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      sck_sync_q    <= sck_sync_d;
      sdi_sync_q    <= sdi_sync_d;
      cs_sync_q     <= cs_sync_d;
      sck_prev_q    <= sck_s;
      cs_prev_q     <= cs_s;
      state_q       <= state_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      eval_q        <= eval_d;
      command_q     <= command_d;
      databyte1_q   <= databyte1_d;
      databyte2_q   <= databyte2_d;
      spi_done_q    <= spi_done_d;
      frame_error_q <= frame_error_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.command     = command_q;
  assign bus.databyte1   = databyte1_q;
  assign bus.databyte2   = databyte2_q;
  assign bus.spi_done    = spi_done_q;
  assign bus.frame_error = frame_error_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed bench for spi_frame_receiver: valid/short/long/empty frames,
// back-to-back frames, sck noise with cs_n high, and reset mid-frame.
module tb_spi_frame_receiver;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  int   tot_done = 0;
  int   tot_err = 0;

  spi_frame_if bus ();

  spi_frame_receiver #(.SYNC_STAGES(2), .FRAME_BITS(24)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.spi_done)    tot_done++;
    if (bus.frame_error) tot_err++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Mode 0: data set while sck low, sck held 2 clk per phase (clk/4).
  task automatic send_bit(input logic b);
    bus.sdi = b;
    repeat (2) @(negedge clk);
    bus.sck = 1'b1;
    repeat (2) @(negedge clk);
    bus.sck = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic start_frame();
    bus.cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Raises cs_n and watches the strobes; spi_done/frame_error due at the 4th clk.
  task automatic end_frame(input string tag, input bit exp_done);
    int nd, ne, at;
    nd = 0; ne = 0; at = 0;
    repeat (2) @(negedge clk);
    bus.cs_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.spi_done || bus.frame_error) begin
        if (at == 0) at = c;
      end
      if (bus.spi_done)    nd++;
      if (bus.frame_error) ne++;
    end
    chk({tag, "_done_cnt"}, nd, exp_done ? 1 : 0);
    chk({tag, "_err_cnt"},  ne, exp_done ? 0 : 1);
    chk({tag, "_latency"},  at, 4);
    chk({tag, "_busy_idle"}, bus.busy, 0);
  endtask

  task automatic chk_out(input string tag, input logic [23:0] exp);
    chk({tag, "_cmd"}, bus.command,   exp[23:16]);
    chk({tag, "_db1"}, bus.databyte1, exp[15:8]);
    chk({tag, "_db2"}, bus.databyte2, exp[7:0]);
  endtask

  initial begin
    int d0, e0, nd, at;
    logic b_low;
    reset = 1'b1;
    bus.sck = 1'b0; bus.sdi = 1'b0; bus.cs_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_out("rst", 24'h000000);
    chk("rst_done", bus.spi_done, 0);
    chk("rst_err",  bus.frame_error, 0);
    chk("rst_busy", bus.busy, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Valid frame
    start_frame();
    chk("valid_busy", bus.busy, 1);
    send_bits(32'hA503FF, 24);
    end_frame("valid", 1'b1);
    chk_out("valid", 24'hA503FF);

    // Short frame keeps previous outputs
    start_frame(); send_bits(32'h112233, 24); end_frame("pre", 1'b1);
    chk_out("pre", 24'h112233);
    start_frame(); send_bits(32'h7FFFFF, 23); end_frame("short", 1'b0);
    chk_out("short", 24'h112233);

    // Long and zero-bit frames
    start_frame(); send_bits(32'h1ABCDEF, 25); end_frame("long", 1'b0);
    chk_out("long", 24'h112233);
    start_frame(); end_frame("zero", 1'b0);
    chk_out("zero", 24'h112233);

    // Back-to-back with cs_n high for 3 clk cycles
    start_frame();
    send_bits(32'h010203, 24);
    repeat (2) @(negedge clk);
    bus.cs_n = 1'b1;
    nd = 0; at = 0; b_low = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (bus.spi_done) begin nd++; if (at == 0) at = c; end
      if (c == 3) bus.cs_n = 1'b0;
      if (c == 4) b_low = bus.busy;
    end
    chk("b2b1_done_cnt", nd, 1);
    chk("b2b1_latency", at, 4);
    chk("b2b_busy_gap", b_low, 0);
    chk_out("b2b1", 24'h010203);
    repeat (2) @(negedge clk);
    chk("b2b2_busy", bus.busy, 1);
    send_bits(32'h040506, 24);
    end_frame("b2b2", 1'b1);
    chk_out("b2b2", 24'h040506);

    // sck noise with cs_n high
    d0 = tot_done; e0 = tot_err;
    send_bits(32'h0000A5C3, 16);
    repeat (4) @(negedge clk);
    chk("noise_done", tot_done - d0, 0);
    chk("noise_err",  tot_err - e0, 0);
    chk("noise_busy", bus.busy, 0);
    chk_out("noise", 24'h040506);
    start_frame(); send_bits(32'hC01F80, 24); end_frame("after_noise", 1'b1);
    chk_out("after_noise", 24'hC01F80);

    // Reset after 10 bits, released with cs_n still low: 14 counted bits
    start_frame();
    send_bits(32'h2AB, 10);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_out("midrst", 24'h000000);
    chk("midrst_done", bus.spi_done, 0);
    chk("midrst_err",  bus.frame_error, 0);
    chk("midrst_busy", bus.busy, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_recv", bus.busy, 1);
    send_bits(32'h3A5C, 14);
    end_frame("midrst", 1'b0);
    chk_out("midrst_end", 24'h000000);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/spi_frame_receiver.md
Name: spi_frame_receiver

Overview:
SPI slave front end that sits directly upstream of the command decoder. It brings the MCU's SPI pins (sck, sdi, cs_n) into the clk domain and deserialises each chip-select-framed transaction into three bytes: command, databyte1 and databyte2. A one-cycle spi_done strobe marks each valid frame. Malformed frames are dropped, so the decoder only ever sees complete 24-bit frames.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the synchronisers on sck, sdi and cs_n (minimum 2).
FRAME_BITS, 24, exact bit count that makes a valid frame; fixed at 3 bytes × 8 bits.

Ports:
clk  input  1  system clock; sole clock of the block.
reset  input  1  asynchronous, active-high reset.
sck  input  1  SPI clock from MCU, asynchronous to clk.
sdi  input  1  SPI data, MCU to FPGA, MSB first.
cs_n  input  1  SPI chip select, active low; one low period is one frame.
command  output  8  first byte of the last valid frame.
databyte1  output  8  second byte of the last valid frame.
databyte2  output  8  third byte of the last valid frame.
spi_done  output  1  one-cycle pulse: command/databyte1/databyte2 were updated this cycle.
frame_error  output  1  one-cycle pulse: a frame was discarded.
busy  output  1  high while a frame is being received (state RECV).

Behaviour:
- Reset: all outputs 0. Shift register and bit counter cleared. State IDLE.
- Synchroniser reset values: sck=0, sdi=0, cs_n=1.
- SPI mode 0 only:
  - sdi is sampled on rising sck.
  - sck and sdi use equal synchroniser depth, so their relative alignment is preserved.
  - Supported sck frequency is ≤ clk/4.
- Edge detection: registered copy of each synced signal. A rise is synced=1 with previous=0; a fall is the reverse.
- State machine (2 states):
  - IDLE: busy=0 and sck edges are ignored. A cs_n fall clears the shift register and bit counter, then moves to RECV.
  - RECV: busy=1.
    - On each sck rise while synced cs_n=0: shift_reg <= {shift_reg[22:0], sdi_sync}.
    - Bit counter increments and saturates at FRAME_BITS+1 (5-bit counter).
    - On a cs_n rise, move to IDLE and evaluate the frame.
- Frame evaluation, registered in the cycle after the cs_n rise is detected:
  - Count == 24: command <= shift_reg[23:16], databyte1 <= [15:8], databyte2 <= [7:0]; spi_done=1 for exactly 1 cycle.
  - Count ≠ 24 (short, long or zero): frame_error=1 for 1 cycle. Outputs keep their previous values and spi_done stays 0.
- Latency: spi_done is high in clk cycle SYNC_STAGES+2 after the first clk edge that samples raw cs_n high. This is 4 cycles at the default depth.
- Data outputs are stable from the spi_done cycle until the next valid frame. They never change without spi_done.
- Simultaneous events:
  - An sck rise detected in the same cycle as the cs_n rise is ignored, because synced cs_n is already 1.
  - An sck rise in the same cycle as the cs_n fall is also ignored; the first counted bit comes after the fall.
- A cs_n fall detected while in RECV cannot occur without an intervening rise. If it does, through a glitch shorter than the synchroniser, the counter and shift register restart.
- spi_done and frame_error are mutually exclusive and never assert on consecutive cycles from the same frame.
- Back-to-back frames: cs_n high for ≥ SYNC_STAGES+1 clk cycles between frames guarantees both edges are seen.
- Reset mid-frame:
  - The partial frame is lost and no strobe is produced.
  - If cs_n is still low at reset release, the synchroniser (reset to 1) reports a fall and RECV starts mid-transaction.
  - The resulting frame has fewer than 24 counted bits and ends in frame_error. This behaviour is required.
- sck toggling while cs_n is high changes no state.

Test Plan:
- Valid frame: cs_n low, shift 24 bits 0xA5, 0x03, 0xFF MSB-first, cs_n high → command=0xA5, databyte1=0x03, databyte2=0xFF. spi_done high for exactly 1 clk cycle, 4 cycles after raw cs_n rise. frame_error stays 0.
- Short frame: 23 bits after a prior valid 0x11,0x22,0x33 frame → frame_error one-cycle pulse, no spi_done, outputs remain 0x11/0x22/0x33.
- Long frame: 25 bits → frame_error pulse, outputs unchanged. Zero-bit frame (cs_n low then high, no sck) → frame_error pulse.
- Back-to-back: frames 0x01,0x02,0x03 then 0x04,0x05,0x06 with cs_n high 3 clk cycles between → two spi_done pulses, outputs update in order; busy low between frames.
- Noise: 16 sck pulses with cs_n high, then a valid frame 0xC0,0x1F,0x80 → only the valid frame is reported, with correct bytes.
- Reset: assert reset after 10 bits and release with cs_n low; finish the frame → all outputs 0 during reset, then frame_error (count 14), no spi_done.
